fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle decode/controller path.
- Owns the PC register and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Presents the fetched instruction, its PC and PC+4 downstream with a valid/ready handshake.
- Consumes the controller's PCSrc and the datapath's PCTarget to select the next PC when the presented instruction retires.

Parameters:
XLEN, 32, PC and address width
RESET_PC, 32'h0000_0000, PC loaded on reset (must be 4-byte aligned)

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  asynchronous active-high reset
PCSrc  input  1  from controller: take PCTarget for the retiring instruction
PCTarget  input  XLEN  branch/jump target for the retiring instruction
imem_req  output  1  request valid
imem_addr  output  XLEN  request address (current PC)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
instr  output  32  held instruction
instr_pc  output  XLEN  PC of instr
instr_pcplus4  output  XLEN  instr_pc + 4, modulo 2^XLEN
instr_valid  output  1  instr/instr_pc/instr_pcplus4 are valid
instr_ready  input  1  downstream accepts (retires) the instruction
fetch_fault  output  1  sticky misaligned-target fault
instret  output  32  count of retired instructions

Behaviour:
- Reset (async, any state) forces:
  - state=IDLE, pc=RESET_PC
  - imem_req=0, instr_valid=0, fetch_fault=0
  - instr=0, instr_pc=0, instr_pcplus4=0, instret=0
- Reset mid-transaction abandons the transaction; imem shares the same reset, so no stale response is expected.
- FSM states IDLE, REQ, WAIT, HOLD, FAULT:
  - IDLE: lasts exactly one cycle after reset release, then moves to REQ.
  - REQ: imem_req=1, imem_addr=pc. imem_gnt=1 moves to WAIT; otherwise hold req and addr stable.
  - WAIT: imem_req=0. imem_rvalid=1 captures instr=imem_rdata, instr_pc=pc, instr_pcplus4=pc+4, then moves to HOLD. imem_rvalid is ignored in every state except WAIT.
  - HOLD: instr_valid=1 and outputs stable. When instr_ready=1:
    - retire; instret increments (wraps at 2^32);
    - next = PCSrc ? PCTarget : instr_pcplus4;
    - if next[1:0] != 0: fetch_fault<=1 and move to FAULT;
    - otherwise pc<=next and move to REQ.
  - HOLD with instr_ready=0: stay; PCSrc and PCTarget are don't-care.
  - FAULT: instr_valid=0, imem_req=0, fetch_fault=1; leaves only on reset.
- imem_gnt and imem_rvalid in the same cycle is illegal; rvalid comes no earlier than the cycle after gnt.
- Only one request is ever outstanding.
- instr_valid drops in the cycle after retirement.
- Zero-wait latency (gnt in first REQ cycle, rvalid in first WAIT cycle):
  - reset release to first instr_valid = 3 cycles (IDLE, REQ, WAIT);
  - retirement to next instr_valid = 3 cycles (HOLD, REQ, WAIT).
- PC arithmetic wraps: pc=0xFFFF_FFFC gives instr_pcplus4=0x0000_0000.
- PCTarget is used as given; no offset is added here.
- imem_addr equals pc in all states; it is only meaningful while imem_req=1.

Test Plan:
- Reset release, imem zero-wait returning 0x00500093 at 0x0: imem_req at cycle 1 with addr 0x0; instr_valid at cycle 3, instr=0x00500093, instr_pc=0x0, instr_pcplus4=0x4, instret=0.
- Sequential flow, instr_ready=1 and PCSrc=0 for three instructions: imem_addr sequence 0x0, 0x4, 0x8; instret=3 after the third handshake.
- Backpressure, instr_ready=0 for 5 cycles in HOLD with imem_rvalid toggling: instr stays unchanged, no imem_req, instret stays constant.
- Redirect, PCSrc=1 with PCTarget=0x100 at retirement of the instr at 0x8: next imem_addr=0x100; a 3-cycle gnt stall keeps imem_req=1 and addr=0x100 stable.
- Misaligned target, PCSrc=1 with PCTarget=0x102: fetch_fault=1 the next cycle, no further imem_req, instr_valid=0 until reset.
- Asynchronous reset asserted mid-WAIT: outputs return to reset values immediately (no clock edge); the next fetch goes to RESET_PC. Wrap case: pc=0xFFFF_FFFC gives instr_pcplus4=0x0 and the next request at 0x0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus and downstream instruction handshake for fetch_unit.
// master = fetch side, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pcplus4;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr, instr_pc, instr_pcplus4, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr, instr_pc, instr_pcplus4, instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, holds the fetched
// instruction until downstream retires it, then selects the next PC.
//
// state | meaning
// IDLE  | one cycle after reset release
// REQ   | imem_req high at pc, waiting for gnt
// WAIT  | request accepted, waiting for rvalid
// HOLD  | instruction presented, waiting for instr_ready
// FAULT | misaligned next PC seen; parked until reset
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  fetch_unit_if.master    bus,
  output logic            fetch_fault,
  output logic [31:0]     instret
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pcplus4;
  logic [XLEN-1:0] next_pc;
  logic [31:0]     instr;
  logic            retire;
  logic            misaligned;
  logic            capture;

  assign retire     = (state == HOLD) && bus.instr_ready;
  assign capture    = (state == WAIT) && bus.imem_rvalid;
  assign next_pc    = PCSrc ? PCTarget : instr_pcplus4;
  assign misaligned = |next_pc[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (bus.imem_gnt) state_nxt = WAIT;
      WAIT:    if (bus.imem_rvalid) state_nxt = HOLD;
      HOLD:    if (bus.instr_ready) state_nxt = misaligned ? FAULT : REQ;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state == REQ);
    bus.instr_valid = (state == HOLD);
    fetch_fault     = (state == FAULT);
  end

  // A faulting retirement still counts, but leaves pc at the faulting instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= RESET_PC;
      instr         <= '0;
      instr_pc      <= '0;
      instr_pcplus4 <= '0;
      instret       <= '0;
    end else begin
      if (capture) begin
        instr         <= bus.imem_rdata;
        instr_pc      <= pc;
        instr_pcplus4 <= pc + XLEN'(4);
      end
      if (retire) begin
        instret <= instret + 32'd1;
        if (!misaligned) pc <= next_pc;
      end
    end
  end

  assign bus.imem_addr     = pc;
  assign bus.instr         = instr;
  assign bus.instr_pc      = instr_pc;
  assign bus.instr_pcplus4 = instr_pcplus4;

endmodule
